// File: rtl/gsm_pkg.sv
// Shared constants for the game state manager command path: flag codes,
// game state codes and the issuer FSM state encoding.
package gsm_pkg;

  localparam logic [3:0] FLAG_SCORE_INC   = 4'b0001;
  localparam logic [3:0] FLAG_LIFE_DEC    = 4'b0010;
  localparam logic [3:0] FLAG_PAUSE       = 4'b0100;
  localparam logic [3:0] FLAG_RESUME      = 4'b0101;
  localparam logic [3:0] FLAG_TO_READY    = 4'b1000;
  localparam logic [3:0] FLAG_TO_PLAY     = 4'b1010;
  localparam logic [3:0] FLAG_STAGE_CLEAR = 4'b1100;
  localparam logic [3:0] FLAG_GAME_OVER   = 4'b1101;
  localparam logic [3:0] FLAG_GAME_CLEAR  = 4'b1110;
  localparam logic [3:0] FLAG_RESET_ALL   = 4'b1111;

  localparam logic [2:0] READY       = 3'b001;
  localparam logic [2:0] PLAYING     = 3'b010;
  localparam logic [2:0] GAME_OVER   = 3'b011;
  localparam logic [2:0] STAGE_CLEAR = 3'b100;
  localparam logic [2:0] GAME_CLEAR  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2
  } issuer_state_t;

endpackage

// File: rtl/gsm_cmd_fifo.sv
// In-order command queue with async reset. Pushes while full and pops while
// empty are ignored; pointers wrap modulo DEPTH (power of two).
module gsm_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                     clk_1mhz,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_1mhz) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk_1mhz or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/gsm_cmd_issuer.sv
// Serialises queued command flags onto the flag/trig/done interface:
// trig is held until done or timeout, then kept low for a fixed gap.
module gsm_cmd_issuer
  import gsm_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 15,
  parameter int GAP_CYCLES     = 3
) (
  input  logic                   clk_1mhz,
  input  logic                   rst,
  input  logic                   cmd_valid,
  input  logic [3:0]             cmd_flag,
  output logic                   cmd_ready,
  output logic [3:0]             flag,
  output logic                   trig,
  input  logic                   done,
  output logic                   busy,
  output logic                   timeout_err,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level,
  output issuer_state_t          state_dbg
);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  issuer_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    flag_q, flag_d;
  logic          timeout_q, timeout_d;
  logic          pop;
  logic          full;
  logic          empty;
  logic [3:0]    head;

  gsm_cmd_fifo #(.DEPTH(DEPTH), .W(4)) u_fifo (
    .clk_1mhz (clk_1mhz),
    .rst      (rst),
    .push     (cmd_valid),
    .din      (cmd_flag),
    .pop      (pop),
    .dout     (head),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

  always_ff @(posedge clk_1mhz or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      flag_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flag_q    <= flag_d;
      timeout_q <= timeout_d;
    end
  end

  // done wins over the timeout when both land on the same edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    flag_d    = flag_q;
    timeout_d = 1'b0;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          flag_d  = head;
          cnt_d   = '0;
          state_d = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (done) begin
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          cnt_d     = '0;
          timeout_d = 1'b1;
          state_d   = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // trig decodes the state register so an async reset drops it at once.
  assign trig        = (state_q == ST_ASSERT);
  assign flag        = flag_q;
  assign timeout_err = timeout_q;
  assign cmd_ready   = ~full;
  assign overflow    = cmd_valid & full;
  assign busy        = (state_q != ST_IDLE) | (level != '0);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_gsm_cmd_issuer.sv
// Randomized scoreboard bench for gsm_cmd_issuer with a done-responder model.
module tb_gsm_cmd_issuer;
  import gsm_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;
  localparam int GAP     = 3;

  logic          clk_1mhz = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic [3:0]    cmd_flag;
  logic          cmd_ready;
  logic [3:0]    flag;
  logic          trig;
  logic          done;
  logic          busy;
  logic          timeout_err;
  logic          overflow;
  logic [2:0]    level;
  issuer_state_t state_dbg;

  int vectors    = 0;
  int miscompares = 0;
  logic [3:0] exp_q[$];

  logic mon_en      = 1'b0;
  logic spurious_en = 1'b0;
  int   ack_lo      = 3;
  int   ack_hi      = 3;
  int   cur_ack     = 3;

  logic [3:0] flag_tab [10] = '{FLAG_SCORE_INC, FLAG_LIFE_DEC, FLAG_PAUSE, FLAG_RESUME,
                                FLAG_TO_READY, FLAG_TO_PLAY, FLAG_STAGE_CLEAR,
                                FLAG_GAME_OVER, FLAG_GAME_CLEAR, FLAG_RESET_ALL};

  gsm_cmd_issuer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT), .GAP_CYCLES(GAP)) dut (
    .clk_1mhz    (clk_1mhz),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_flag    (cmd_flag),
    .cmd_ready   (cmd_ready),
    .flag        (flag),
    .trig        (trig),
    .done        (done),
    .busy        (busy),
    .timeout_err (timeout_err),
    .overflow    (overflow),
    .level       (level),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  always #5 clk_1mhz = ~clk_1mhz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks: entered and left just after a rising edge
  task automatic push_cmd(input logic [3:0] f);
    cmd_valid = 1'b1;
    cmd_flag  = f;
    @(posedge clk_1mhz);
    if (exp_q.size() < DEPTH) exp_q.push_back(f);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk_1mhz);
      #1;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || trig) && n < budget) begin
      @(posedge clk_1mhz);
      #1;
      n++;
    end
    check("drain_budget", n < budget, 1);
  endtask

  // state manager model: acks cur_ack cycles after trig rises, optional stray pulses
  initial begin : responder
    int rhc;
    rhc  = 0;
    done = 1'b0;
    forever begin
      @(negedge clk_1mhz);
      done = 1'b0;
      if (rst) begin
        rhc = 0;
      end else if (trig) begin
        if (rhc == 0) cur_ack = $urandom_range(ack_hi, ack_lo);
        rhc++;
        if (rhc == cur_ack) done = 1'b1;
      end else begin
        rhc = 0;
        if (spurious_en && $urandom_range(2, 0) == 0) done = 1'b1;
      end
    end
  end

  // monitor / scoreboard
  initial begin : monitor
    logic       trig_prev;
    logic       should_rise;
    logic       issued_any;
    logic       exp_to;
    logic [3:0] cur_exp;
    int         hi_cnt;
    int         low_cnt;
    int         prev_size;
    int         exp_dur;
    trig_prev = 1'b0; should_rise = 1'b0; issued_any = 1'b0; cur_exp = '0;
    hi_cnt = 0; low_cnt = 1000; prev_size = 0;
    forever begin
      @(negedge clk_1mhz);
      if (!mon_en) begin
        trig_prev = 1'b0; should_rise = 1'b0; issued_any = 1'b0;
        hi_cnt = 0; low_cnt = 1000; prev_size = 0;
      end else begin
        exp_dur = (cur_ack < TIMEOUT) ? cur_ack : TIMEOUT;
        exp_to  = (cur_ack > TIMEOUT);
        if (should_rise) check("issue_latency", trig, 1);
        if (trig && !trig_prev) begin
          check("gap_before_trig", low_cnt >= GAP + 1, 1);
          check("no_bypass", prev_size > 0, 1);
          if (exp_q.size() == 0) check("extra_trig", trig, 0);
          else begin
            cur_exp    = exp_q.pop_front();
            issued_any = 1'b1;
          end
          hi_cnt = 0;
        end
        if (trig) hi_cnt++;
        if (trig || issued_any) check("flag_value", flag, cur_exp);
        if (!trig && trig_prev) begin
          check("trig_width", hi_cnt, exp_dur);
          low_cnt = 0;
        end
        check("timeout_err", timeout_err, (!trig && trig_prev) ? exp_to : 1'b0);
        if (!trig && low_cnt < 1000) low_cnt++;
        check("level", level, exp_q.size());
        check("cmd_ready", cmd_ready, exp_q.size() < DEPTH);
        check("overflow", overflow, cmd_valid && (exp_q.size() == DEPTH));
        check("busy", busy, (exp_q.size() != 0) || trig || (low_cnt <= GAP));
        should_rise = !trig && (low_cnt >= GAP + 1) && (exp_q.size() > 0);
        prev_size   = exp_q.size();
        trig_prev   = trig;
      end
    end
  end

  initial begin : watchdog
    #600000;
    miscompares++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : stimulus
    int n;
    rst = 1'b0; cmd_valid = 1'b0; cmd_flag = '0;
    #1 rst = 1'b1;
    #1;
    check("rst_trig", trig, 0);
    check("rst_flag", flag, 0);
    check("rst_level", level, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_overflow", overflow, 0);
    repeat (2) @(posedge clk_1mhz);
    #2 rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk_1mhz);
    #1;

    // single command, ack 3 cycles after trig
    ack_lo = 3; ack_hi = 3;
    push_cmd(FLAG_SCORE_INC);
    drain(100);

    // back-to-back pushes
    ack_lo = 1; ack_hi = 6;
    push_cmd(FLAG_SCORE_INC);
    push_cmd(FLAG_LIFE_DEC);
    push_cmd(FLAG_TO_PLAY);
    drain(200);

    // stray done pulses in IDLE and RELEASE
    spurious_en = 1'b1;
    idle_cycles(10);
    push_cmd(FLAG_PAUSE);
    drain(100);
    idle_cycles(10);
    spurious_en = 1'b0;

    // timeout, then the next queued command proceeds
    ack_lo = 99; ack_hi = 99;
    push_cmd(FLAG_STAGE_CLEAR);
    push_cmd(FLAG_RESUME);
    drain(200);

    // overflow: never acked, six pushes into a depth-4 queue
    push_cmd(FLAG_SCORE_INC);
    push_cmd(FLAG_LIFE_DEC);
    push_cmd(FLAG_PAUSE);
    push_cmd(FLAG_RESUME);
    push_cmd(FLAG_TO_READY);
    push_cmd(FLAG_GAME_OVER);
    drain(400);

    // done exactly on the timeout edge, and one cycle too late
    ack_lo = 15; ack_hi = 15;
    push_cmd(FLAG_GAME_CLEAR);
    drain(100);
    ack_lo = 16; ack_hi = 16;
    push_cmd(FLAG_RESET_ALL);
    drain(100);

    // randomized traffic
    ack_lo = 1; ack_hi = 16;
    spurious_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      push_cmd(flag_tab[$urandom_range(9, 0)]);
      idle_cycles($urandom_range(3, 0));
    end
    drain(4000);
    spurious_en = 1'b0;

    // reset while trig is high with two commands queued
    ack_lo = 99; ack_hi = 99;
    push_cmd(FLAG_SCORE_INC);
    push_cmd(FLAG_LIFE_DEC);
    push_cmd(FLAG_TO_PLAY);
    n = 0;
    while (!trig && n < 10) begin
      idle_cycles(1);
      n++;
    end
    check("trig_before_reset", trig, 1);
    idle_cycles(2);
    #2;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst_trig", trig, 0);
    check("async_rst_level", level, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_ready", cmd_ready, 1);
    check("async_rst_flag", flag, 0);
    exp_q.delete();
    @(negedge clk_1mhz);
    #2 rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk_1mhz);
    #1;
    idle_cycles(30);
    ack_lo = 2; ack_hi = 2;
    push_cmd(FLAG_TO_READY);
    drain(100);
    idle_cycles(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
